fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that consumes the current program counter from the PC register, reads the instruction memory over a req/ack handshake, and returns the next PC value plus a load strobe to the PC register. Fetched instructions, tagged with their address, are buffered in a 2-entry FIFO and presented to decode over a valid/ready interface. Branch/jump redirects flush the buffer and discard any in-flight memory read.

## Interface
- AW, 8: address / PC width in bits
- IW, 32: instruction width in bits
- INC, 1: PC increment per instruction (word-addressed memory)

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- pc_in  input  AW  current PC register value
- pc_next  output  AW  value the PC register loads when pc_load is high
- pc_load  output  1  PC register load enable for the coming edge (combinational)
- imem_req  output  1  memory read request (registered)
- imem_addr  output  AW  memory read address (registered)
- imem_ack  input  1  memory read complete; imem_rdata valid this cycle
- imem_rdata  input  IW  read data
- redirect  input  1  branch/jump taken, single-cycle pulse or level
- redirect_pc  input  AW  target address
- inst_valid  output  1  FIFO head valid
- inst_ready  input  1  decode accepts head
- inst_data  output  IW  FIFO head instruction
- inst_pc  output  AW  FIFO head address

## Operation
- Reset (asynchronous, rst_n low): state IDLE, imem_req 0, imem_addr 0, FIFO empty, inst_valid 0, inst_data 0, inst_pc 0; pc_load 0 while rst_n low.
- FSM states: IDLE (no read outstanding), WAIT (read outstanding, result wanted), KILL (read outstanding, result to be discarded).
- IDLE: if FIFO count < 2 and redirect low -> imem_addr <= pc_in, imem_req <= 1, go WAIT; else stay.
- WAIT, imem_ack high, redirect low: push {imem_addr, imem_rdata}; pc_load = 1, pc_next = imem_addr + INC (modulo 2^AW); imem_req <= 0; go IDLE.
- WAIT, imem_ack low, redirect high: go KILL; imem_req and imem_addr held.
- WAIT, imem_ack high, redirect high: data discarded, imem_req <= 0, go IDLE.
- KILL: hold imem_req/imem_addr until imem_ack; on ack discard data, imem_req <= 0, go IDLE.
- imem_req, once raised, stays high with imem_addr stable until ack sampled; at most one read outstanding.
- redirect (any state): pc_load = 1, pc_next = redirect_pc in the same cycle; FIFO flushed at the edge (a simultaneous pop or push is void). Redirect has priority over ack-driven pc_load.
- When pc_load low, pc_next = pc_in + INC (don't-care for the PC).
- FIFO: 2 entries, inst_valid = count != 0; pop when inst_valid && inst_ready. A read is issued only when count < 2, so a push never finds the FIFO full; push and pop in the same cycle leave count unchanged.
- Head outputs hold stable while inst_valid && !inst_ready.

## Timing
- Zero-wait memory (ack in cycle after req rises): edge E0 issue, ack sampled E1 (push, PC loads), inst_valid high after E1, next issue at E2. Peak throughput 1 instruction / 2 cycles.
- Issue latency from IDLE with space: imem_req high 1 cycle after pc_in sampled.
- Redirect in IDLE: no issue that edge; pc_in = redirect_pc after the edge; issue on the following edge.
- Redirect while FIFO full: flush makes space; issue follows per IDLE rule.
- PC wrap: imem_addr 2^AW-1 with INC 1 -> pc_next 0.

## Test plan
- Reset, zero-wait memory, bench PC model loads pc_next on pc_load, rdata = {24'h0, addr}: inst_pc 0x00, 0x01, 0x02 in order with matching data, first inst_valid at or before the 3rd edge after rst_n rises.
- Backpressure: inst_ready 0 -> two entries buffered, imem_req stays 0, head stable at 0x00; ready 1 -> 0x00, 0x01, 0x02 delivered, no drop or duplicate.
- Redirect in WAIT with ack delayed 3 cycles: redirect_pc 0x40 -> pc_load 1, pc_next 0x40 same cycle; FSM to KILL, late data dropped, next inst_pc 0x40.
- Redirect coincident with ack at imem_addr 0x05: pc_next 0x40 (not 0x06), addr 0x05 never appears on inst_pc, FIFO empty next cycle.
- Wrap: pc_in 0xFF, ack -> pc_next 0x00, inst_pc 0xFF, following fetch at 0x00.
- rst_n low mid-WAIT with FIFO holding one entry: imem_req, inst_valid drop immediately (before next edge); after release, fetching restarts from pc_in with FIFO empty.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem read at a time from the PC register,
// buffers tagged instructions in a 2-entry FIFO and handles redirect flushes.
module fetch_unit #(
  parameter int AW  = 8,
  parameter int IW  = 32,
  parameter int INC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] pc_next,
  output logic          pc_load,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_data,
  output logic [AW-1:0] inst_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

  state_t        state;
  logic [1:0]    count;
  logic [AW-1:0] pc_q0, pc_q1;
  logic [IW-1:0] data_q0, data_q1;
  logic          push;
  logic          pop;
  logic [1:0]    wr_idx;

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] a);
    return a + AW'(INC);
  endfunction

  assign push   = (state == WAIT) && imem_ack && !redirect;
  assign pop    = inst_valid && inst_ready;
  assign wr_idx = count - {1'b0, pop};

  assign inst_valid = (count != 2'd0);
  assign inst_data  = data_q0;
  assign inst_pc    = pc_q0;

  // Redirect outranks the ack-driven load; nothing loads while in reset.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc_inc(pc_in);
    if (rst_n) begin
      if (redirect) begin
        pc_load = 1'b1;
        pc_next = redirect_pc;
      end else if (push) begin
        pc_load = 1'b1;
        pc_next = pc_inc(imem_addr);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((count < 2'd2) && !redirect) begin
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (redirect) begin
            state <= KILL;
          end
        end
        KILL: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slot 0 is the head; a pop shifts slot 1 down before the push lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      pc_q0   <= '0;
      pc_q1   <= '0;
      data_q0 <= '0;
      data_q1 <= '0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        pc_q0   <= pc_q1;
        data_q0 <= data_q1;
      end
      if (push && (wr_idx == 2'd0)) begin
        pc_q0   <= imem_addr;
        data_q0 <= imem_rdata;
      end
      if (push && (wr_idx == 2'd1)) begin
        pc_q1   <= imem_addr;
        data_q1 <= imem_rdata;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register model and a variable-latency memory.
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] pc_next;
  logic          pc_load;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  logic [AW-1:0] pc_reg;
  int            ack_delay;
  int            wait_cnt;
  int            checks;
  int            failures;
  logic [AW-1:0] got_pc[$];
  logic [IW-1:0] got_data[$];

  fetch_unit #(.AW(AW), .IW(IW), .INC(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_next     (pc_next),
    .pc_load     (pc_load),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pc_in      = pc_reg;
  assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
  assign imem_rdata = {24'h0, imem_addr};

  always @(posedge clk) begin
    if (pc_load) pc_reg <= pc_next;
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (rst_n && inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_data.push_back(inst_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input logic [AW-1:0] pc0, input int dly, input logic rdy);
    @(negedge clk);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = rdy;
    ack_delay   = dly;
    pc_reg      = pc0;
    cycles(2);
    got_pc.delete();
    got_data.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    wait_cnt    = 0;
    ack_delay   = 0;
    pc_reg      = '0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;

    // Reset state
    cycles(2);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_pcload", pc_load, 0);

    // Zero-wait streaming from 0x00
    do_reset(8'h00, 0, 1'b1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 3 && !seen; i++) begin
        @(negedge clk);
        if (inst_valid) seen = 1;
      end
      chk("t1_first_valid", seen, 1);
    end
    cycles(8);
    chk("t1_count", got_pc.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_pc%0d", i), got_pc[i], i);
      chk($sformatf("t1_data%0d", i), got_data[i], i);
    end

    // Backpressure: FIFO fills, fetch stops, head holds
    do_reset(8'h00, 0, 1'b0);
    cycles(10);
    chk("t2_valid", inst_valid, 1);
    chk("t2_req_idle", imem_req, 0);
    chk("t2_head_pc", inst_pc, 8'h00);
    cycles(4);
    chk("t2_head_hold", inst_pc, 8'h00);
    chk("t2_pc_reg", pc_reg, 8'h02);
    inst_ready = 1'b1;
    cycles(10);
    chk("t2_count", got_pc.size() >= 3, 1);
    for (int i = 0; i < got_pc.size(); i++)
      chk($sformatf("t2_seq%0d", i), got_pc[i], i);

    // Redirect while waiting on a slow read
    do_reset(8'h10, 3, 1'b1);
    @(negedge clk);
    chk("t3_req", imem_req, 1);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk("t3_pcload", pc_load, 1);
    chk("t3_pcnext", pc_next, 8'h40);
    @(negedge clk);
    redirect = 1'b0;
    chk("t3_req_held", imem_req, 1);
    chk("t3_addr_held", imem_addr, 8'h10);
    chk("t3_pc_reg", pc_reg, 8'h40);
    cycles(14);
    chk("t3_count", got_pc.size() >= 1, 1);
    chk("t3_first_pc", got_pc[0], 8'h40);
    chk("t3_first_data", got_data[0], 32'h40);

    // Redirect coincident with ack at 0x05
    do_reset(8'h05, 0, 1'b1);
    @(negedge clk);
    chk("t4_ack", imem_ack, 1);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk("t4_pcload", pc_load, 1);
    chk("t4_pcnext", pc_next, 8'h40);
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_empty", inst_valid, 0);
    cycles(6);
    chk("t4_count", got_pc.size() >= 1, 1);
    chk("t4_first_pc", got_pc[0], 8'h40);

    // PC wrap at 0xFF
    do_reset(8'hFF, 0, 1'b1);
    @(negedge clk);
    chk("t5_pcload", pc_load, 1);
    chk("t5_pcnext", pc_next, 8'h00);
    cycles(6);
    chk("t5_count", got_pc.size() >= 2, 1);
    chk("t5_pc0", got_pc[0], 8'hFF);
    chk("t5_data0", got_data[0], 32'hFF);
    chk("t5_pc1", got_pc[1], 8'h00);

    // Asynchronous reset mid-read with one entry buffered
    do_reset(8'h00, 0, 1'b0);
    cycles(2);
    ack_delay = 5;
    @(negedge clk);
    chk("t6_valid_pre", inst_valid, 1);
    chk("t6_req_pre", imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_async", imem_req, 0);
    chk("t6_valid_async", inst_valid, 0);
    chk("t6_pcload_async", pc_load, 0);
    ack_delay  = 0;
    pc_reg     = 8'h20;
    inst_ready = 1'b1;
    @(negedge clk);
    got_pc.delete();
    got_data.delete();
    rst_n = 1'b1;
    chk("t6_empty_after", inst_valid, 0);
    cycles(6);
    chk("t6_count", got_pc.size() >= 1, 1);
    chk("t6_first_pc", got_pc[0], 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
